// File: rtl/burst_ram_arbiter_if.sv
// rtl/burst_ram_arbiter_if.sv - instruction/data client and BurstRAM signal bundle
interface burst_ram_arbiter_if #(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64
);
    localparam int MASK_W = RAM_BURST_DATA_BITWIDTH / 8;

    logic                               i_cmd;
    logic                               i_cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]      i_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] i_rd_data;
    logic                               i_rd_data_valid;
    logic                               i_busy;

    logic                               d_cmd;
    logic                               d_cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]      d_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] d_wr_data;
    logic [MASK_W-1:0]                  d_data_mask;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] d_rd_data;
    logic                               d_rd_data_valid;
    logic                               d_busy;

    logic                               br_cmd;
    logic                               br_cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] br_wr_data;
    logic [MASK_W-1:0]                  br_data_mask;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data;
    logic                               br_rd_data_valid;
    logic                               br_busy;

    // Arbiter side
    modport slave (
        input  i_cmd, i_cmd_en, i_addr,
        output i_rd_data, i_rd_data_valid, i_busy,
        input  d_cmd, d_cmd_en, d_addr, d_wr_data, d_data_mask,
        output d_rd_data, d_rd_data_valid, d_busy,
        output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
        input  br_rd_data, br_rd_data_valid, br_busy
    );

    // Clients and BurstRAM side
    modport master (
        output i_cmd, i_cmd_en, i_addr,
        input  i_rd_data, i_rd_data_valid, i_busy,
        output d_cmd, d_cmd_en, d_addr, d_wr_data, d_data_mask,
        input  d_rd_data, d_rd_data_valid, d_busy,
        input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
        output br_rd_data, br_rd_data_valid, br_busy
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// rtl/burst_ram_arbiter.sv - round-robin arbiter of a read-only I client and a R/W D client onto one BurstRAM
module burst_ram_arbiter #(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic               clk,
    input  logic               rst,
    burst_ram_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(RAM_BURST_DATA_COUNT) + 1;
    localparam logic [CNT_W-1:0] LAST_RD_BEAT = CNT_W'(RAM_BURST_DATA_COUNT - 1);
    localparam logic [CNT_W-1:0] LAST_WR_BEAT = CNT_W'(RAM_BURST_DATA_COUNT - 2);
    localparam bit MULTI_BEAT = (RAM_BURST_DATA_COUNT > 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t           state;
    logic             offer;
    logic             owner;
    logic [CNT_W-1:0] cnt;

    logic idle_free;
    logic i_accept;
    logic d_accept;
    logic write_beat;
    logic unused_i_cmd;

    // Only the offered client ever sees busy low, so a strobe from the other is never accepted.
    always_comb begin
        idle_free  = rst && (state == IDLE) && !bus.br_busy;
        i_accept   = idle_free && !offer && bus.i_cmd_en;
        d_accept   = idle_free && offer && bus.d_cmd_en;
        write_beat = (d_accept && bus.d_cmd) || (state == WRITE);
    end

    assign unused_i_cmd = bus.i_cmd;

    assign bus.i_busy = !(idle_free && !offer);
    assign bus.d_busy = !(idle_free && offer);

    assign bus.br_cmd_en    = i_accept || d_accept;
    assign bus.br_cmd       = offer && bus.d_cmd;
    assign bus.br_addr      = offer ? bus.d_addr : bus.i_addr;
    assign bus.br_wr_data   = bus.d_wr_data;
    assign bus.br_data_mask = write_beat ? bus.d_data_mask : '0;

    assign bus.i_rd_data       = bus.br_rd_data;
    assign bus.d_rd_data       = bus.br_rd_data;
    assign bus.i_rd_data_valid = (state == READ) && !owner && bus.br_rd_data_valid;
    assign bus.d_rd_data_valid = (state == READ) && owner && bus.br_rd_data_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            offer <= 1'b0;
            owner <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.br_busy) begin
                        if (i_accept) begin
                            owner <= 1'b0;
                            cnt   <= '0;
                            state <= READ;
                        end else if (d_accept) begin
                            owner <= 1'b1;
                            cnt   <= '0;
                            if (!bus.d_cmd)
                                state <= READ;
                            else if (MULTI_BEAT)
                                state <= WRITE;
                            else
                                offer <= 1'b0;
                        end else begin
                            offer <= ~offer;
                        end
                    end
                end
                READ: begin
                    if (bus.br_rd_data_valid) begin
                        if (cnt == LAST_RD_BEAT) begin
                            state <= IDLE;
                            offer <= ~owner;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // Beat 0 went out with the command, so WRITE covers the remaining beats.
                    if (cnt == LAST_WR_BEAT) begin
                        state <= IDLE;
                        offer <= ~owner;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb/tb_burst_ram_arbiter.sv - directed self-checking bench for burst_ram_arbiter
module tb_burst_ram_arbiter;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    burst_ram_arbiter_if #(.RAM_DEPTH_BITWIDTH(4), .RAM_BURST_DATA_BITWIDTH(64)) bus ();

    burst_ram_arbiter #(
        .RAM_DEPTH_BITWIDTH(4),
        .RAM_BURST_DATA_BITWIDTH(64),
        .RAM_BURST_DATA_COUNT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [63:0] wdata [4];
        logic [7:0]  wmask [4];
        logic        exp_d;
        n_assert = 0;
        n_fail   = 0;
        wdata[0] = 64'hA0; wdata[1] = 64'hA1; wdata[2] = 64'hA2; wdata[3] = 64'hA3;
        wmask[0] = 8'hF0;  wmask[1] = 8'h0F;  wmask[2] = 8'h3C;  wmask[3] = 8'hC3;

        rst = 1'b0;
        bus.i_cmd = 1'b0; bus.i_cmd_en = 1'b1; bus.i_addr = 4'd0;
        bus.d_cmd = 1'b0; bus.d_cmd_en = 1'b0; bus.d_addr = 4'd0;
        bus.d_wr_data = '0; bus.d_data_mask = '0;
        bus.br_rd_data = '0; bus.br_rd_data_valid = 1'b0; bus.br_busy = 1'b0;

        // Reset state
        #2;
        chk("rst_i_busy", 64'(bus.i_busy), 64'd1);
        chk("rst_d_busy", 64'(bus.d_busy), 64'd1);
        chk("rst_br_cmd_en", 64'(bus.br_cmd_en), 64'd0);
        bus.i_cmd_en = 1'b0;

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_i_busy", 64'(bus.i_busy), 64'd0);
        chk("rel_d_busy", 64'(bus.d_busy), 64'd1);

        // I read: i_cmd=1 must still go out as a read
        bus.i_cmd_en = 1'b1; bus.i_addr = 4'd5; bus.i_cmd = 1'b1;
        #1;
        chk("ird_br_cmd_en", 64'(bus.br_cmd_en), 64'd1);
        chk("ird_br_addr", 64'(bus.br_addr), 64'd5);
        chk("ird_br_cmd", 64'(bus.br_cmd), 64'd0);
        @(negedge clk);
        bus.i_cmd_en = 1'b0; bus.i_cmd = 1'b0;
        #1;
        chk("ird_busy_both", {62'd0, bus.i_busy, bus.d_busy}, 64'd3);
        chk("ird_no_cmd_en", 64'(bus.br_cmd_en), 64'd0);
        for (int k = 0; k < 4; k++) begin
            bus.br_rd_data = 64'h100 + 64'(k);
            bus.br_rd_data_valid = 1'b1;
            #1;
            chk("ird_i_valid", 64'(bus.i_rd_data_valid), 64'd1);
            chk("ird_d_valid", 64'(bus.d_rd_data_valid), 64'd0);
            chk("ird_i_data", bus.i_rd_data, 64'h100 + 64'(k));
            @(negedge clk);
        end
        bus.br_rd_data_valid = 1'b0;
        #1;
        chk("ird_after_d_busy", 64'(bus.d_busy), 64'd0);
        chk("ird_after_i_busy", 64'(bus.i_busy), 64'd1);

        // D write, beat 0 with the command then three more
        bus.d_cmd = 1'b1; bus.d_cmd_en = 1'b1; bus.d_addr = 4'd3;
        bus.d_wr_data = wdata[0]; bus.d_data_mask = wmask[0];
        #1;
        chk("dwr_br_cmd_en", 64'(bus.br_cmd_en), 64'd1);
        chk("dwr_br_cmd", 64'(bus.br_cmd), 64'd1);
        chk("dwr_br_addr", 64'(bus.br_addr), 64'd3);
        chk("dwr_data0", bus.br_wr_data, wdata[0]);
        chk("dwr_mask0", 64'(bus.br_data_mask), 64'(wmask[0]));
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            bus.d_cmd_en = 1'b0;
            bus.d_wr_data = wdata[k]; bus.d_data_mask = wmask[k];
            #1;
            chk("dwr_data", bus.br_wr_data, wdata[k]);
            chk("dwr_mask", 64'(bus.br_data_mask), 64'(wmask[k]));
            chk("dwr_i_busy", 64'(bus.i_busy), 64'd1);
            chk("dwr_no_cmd_en", 64'(bus.br_cmd_en), 64'd0);
        end
        @(negedge clk);
        bus.d_cmd = 1'b0; bus.d_data_mask = 8'hFF; bus.d_wr_data = 64'h55;
        bus.br_rd_data_valid = 1'b1;
        #1;
        chk("dwr_after_i_busy", 64'(bus.i_busy), 64'd0);
        chk("dwr_after_d_busy", 64'(bus.d_busy), 64'd1);
        chk("idle_mask_zero", 64'(bus.br_data_mask), 64'd0);
        chk("idle_wr_data_pass", bus.br_wr_data, 64'h55);
        chk("idle_drop_valid", {62'd0, bus.i_rd_data_valid, bus.d_rd_data_valid}, 64'd0);
        bus.br_rd_data_valid = 1'b0;

        // Round robin with both clients requesting continuously
        bus.i_cmd_en = 1'b1; bus.i_addr = 4'd7;
        bus.d_cmd_en = 1'b1; bus.d_addr = 4'd9; bus.d_cmd = 1'b0;
        for (int b = 0; b < 4; b++) begin
            exp_d = (b % 2) == 1;
            #1;
            chk("rr_cmd_en", 64'(bus.br_cmd_en), 64'd1);
            chk("rr_d_busy", 64'(bus.d_busy), 64'(!exp_d));
            chk("rr_addr", 64'(bus.br_addr), exp_d ? 64'd9 : 64'd7);
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                bus.br_rd_data_valid = 1'b1;
                #1;
                chk("rr_i_valid", 64'(bus.i_rd_data_valid), 64'(!exp_d));
                chk("rr_d_valid", 64'(bus.d_rd_data_valid), 64'(exp_d));
                @(negedge clk);
            end
            bus.br_rd_data_valid = 1'b0;
        end
        bus.i_cmd_en = 1'b0; bus.d_cmd_en = 1'b0;

        // BurstRAM busy in IDLE freezes the offer
        bus.br_busy = 1'b1; bus.i_cmd_en = 1'b1;
        #1;
        chk("brb_busy_both", {62'd0, bus.i_busy, bus.d_busy}, 64'd3);
        chk("brb_no_cmd_en", 64'(bus.br_cmd_en), 64'd0);
        @(negedge clk);
        bus.i_cmd_en = 1'b0; bus.br_busy = 1'b0;
        #1;
        chk("brb_held_i_busy", 64'(bus.i_busy), 64'd0);
        chk("brb_held_d_busy", 64'(bus.d_busy), 64'd1);
        @(negedge clk);
        #1;
        chk("brb_toggle_d_busy", 64'(bus.d_busy), 64'd0);
        chk("brb_toggle_i_busy", 64'(bus.i_busy), 64'd1);

        // Reset in the middle of a D read burst
        bus.d_cmd = 1'b0; bus.d_cmd_en = 1'b1; bus.d_addr = 4'd2;
        @(negedge clk);
        bus.d_cmd_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.br_rd_data_valid = 1'b1;
            #1;
            chk("mid_d_valid", 64'(bus.d_rd_data_valid), 64'd1);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_d_valid", 64'(bus.d_rd_data_valid), 64'd0);
        chk("mid_rst_busy_both", {62'd0, bus.i_busy, bus.d_busy}, 64'd3);
        chk("mid_rst_cmd_en", 64'(bus.br_cmd_en), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_drop_valid", {62'd0, bus.i_rd_data_valid, bus.d_rd_data_valid}, 64'd0);
        chk("mid_offer_i", {62'd0, bus.i_busy, bus.d_busy}, 64'd1);
        @(negedge clk);
        bus.br_rd_data_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/burst_ram_arbiter.md
BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

Interface
REQ-001 SHALL have parameter RAM_DEPTH_BITWIDTH, default 4, BurstRAM address width.
REQ-002 SHALL have parameter RAM_BURST_DATA_BITWIDTH, default 64, bits per burst beat.
REQ-003 SHALL have parameter RAM_BURST_DATA_COUNT, default 4, beats per burst.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 i_cmd, i_cmd_en  in  1 each  instruction-client command (0 = read, 1 = write) and command strobe.
REQ-008 i_addr  in  RAM_DEPTH_BITWIDTH  instruction-client burst address.
REQ-009 i_rd_data  out  RAM_BURST_DATA_BITWIDTH  read beat to instruction client.
REQ-010 i_rd_data_valid, i_busy  out  1 each  read beat strobe and stall to instruction client.
REQ-011 d_cmd, d_cmd_en  in  1 each  data-client command (0 = read, 1 = write) and strobe.
REQ-012 d_addr  in  RAM_DEPTH_BITWIDTH  data-client burst address.
REQ-013 d_wr_data  in  RAM_BURST_DATA_BITWIDTH  data-client write beat.
REQ-014 d_data_mask  in  RAM_BURST_DATA_BITWIDTH/8  data-client byte mask.
REQ-015 d_rd_data  out  RAM_BURST_DATA_BITWIDTH  read beat to data client.
REQ-016 d_rd_data_valid, d_busy  out  1 each  read beat strobe and stall to data client.
REQ-017 br_cmd, br_cmd_en  out  1 each  command and strobe to BurstRAM.
REQ-018 br_addr  out  RAM_DEPTH_BITWIDTH  address to BurstRAM.
REQ-019 br_wr_data  out  RAM_BURST_DATA_BITWIDTH  write beat to BurstRAM.
REQ-020 br_data_mask  out  RAM_BURST_DATA_BITWIDTH/8  byte mask to BurstRAM.
REQ-021 br_rd_data  in  RAM_BURST_DATA_BITWIDTH  read beat from BurstRAM.
REQ-022 br_rd_data_valid, br_busy  in  1 each  read beat strobe and busy from BurstRAM.

Function
REQ-023 SHALL implement FSM states IDLE, READ, WRITE, plus a 1-bit offer pointer (0 = I, 1 = D) and a beat counter of clog2(RAM_BURST_DATA_COUNT)+1 bits.
REQ-024 In IDLE with br_busy=0, SHALL deassert busy only to the offered client; the other client's busy stays 1.
REQ-025 busy SHALL be 1 to both clients in READ and WRITE, and in IDLE while br_busy=1.
REQ-026 In IDLE with br_busy=0, if the offered client asserts cmd_en, SHALL forward its cmd/addr to br_cmd/br_addr with br_cmd_en=1 in the same cycle (combinational, zero latency).
REQ-027 cmd_en from a client whose busy=1 SHALL be ignored and never forwarded.
REQ-028 In IDLE with br_busy=0 and no cmd_en from the offered client, offer SHALL toggle at the next edge.
REQ-029 On accepting a burst, the owner SHALL be latched; offer SHALL point to the non-owner on return to IDLE (round-robin).
REQ-030 The instruction client SHALL be read-only: i_cmd is ignored and br_cmd=0 for its bursts.
REQ-031 Accepted read: next state READ; the counter counts br_rd_data_valid beats; after beat RAM_BURST_DATA_COUNT SHALL return to IDLE at the next edge.
REQ-032 br_rd_data SHALL be broadcast to i_rd_data and d_rd_data; rd_data_valid SHALL go only to the owner, and only in READ.
REQ-033 br_rd_data_valid outside READ SHALL be dropped (both client valids 0).
REQ-034 Accepted D write: beat 0 is d_wr_data/d_data_mask in the cmd_en cycle; state WRITE forwards d_wr_data/d_data_mask for RAM_BURST_DATA_COUNT-1 further cycles, then returns to IDLE.
REQ-035 br_cmd_en SHALL be 0 in READ and WRITE; br_wr_data/br_data_mask SHALL equal the D inputs at all times, with mask forced to 0 outside write beats.

Reset
REQ-036 rst=0 SHALL immediately force: state IDLE, offer=I, counter 0, br_cmd_en=0, both rd_data_valid=0, both busy=1.
REQ-037 Reset during READ/WRITE SHALL abandon the burst; remaining BurstRAM beats are dropped per REQ-033.

Verification
REQ-038 Reset: rst=0 -> i_busy=1, d_busy=1, br_cmd_en=0; release with br_busy=0 -> i_busy=0, d_busy=1.
REQ-039 I read: i_cmd_en=1, i_addr=5, i_cmd=1 -> br_cmd_en=1, br_addr=5, br_cmd=0; 4 valid beats -> i_rd_data_valid x4, d_rd_data_valid=0; then d_busy=0.
REQ-040 D write: d_cmd=1, d_addr=3, data A0..A3 over 4 cycles -> br_wr_data A0..A3 with masks forwarded; i_busy=1 throughout; IDLE then offers I.
REQ-041 Both clients requesting continuously -> bursts granted I, D, I, D; no starvation.
REQ-042 br_busy=1 in IDLE -> both busy=1, cmd_en not forwarded; br_busy=0 -> offer resumes.
REQ-043 rst=0 after 2 of 4 read beats -> IDLE, offer=I; remaining 2 br_rd_data_valid beats produce no client valid.
